// File: rtl/frame_write_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_sched_pkg: shared types and sizing helpers for the scheduler.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package frame_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_GRANT = 2'd2
  } sched_state_t;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int wd_width(input int t);
    return (t <= 1) ? 1 : $clog2(t);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_write_scheduler_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lowest_set_picker: combinational lowest-set-bit selector.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lowest_set_picker
  import frame_sched_pkg::*;
#(
  parameter int NUM_SOURCES = 3,
  parameter int SEL_W       = sel_width(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] i_mask,
  output logic [NUM_SOURCES-1:0] o_onehot,
  output logic [SEL_W-1:0]       o_index,
  output logic                   o_any
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_mask & (~i_mask + {{(NUM_SOURCES-1){1'b0}}, 1'b1});
  assign o_any    = |i_mask;

  always_comb begin
    o_index = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (i_mask[i]) o_index = SEL_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_write_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_write_scheduler: per-frame painter's-order arbiter for the     |
// | frame-buffer write port, with a per-grant watchdog. Rev 1.0          |
// +----------------------------------------------------------------------+
module frame_write_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NUM_SOURCES    = 3,
  parameter int COLOR_DEPTH    = 9,
  parameter int COORD_W        = 32,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int SEL_W          = sel_width(NUM_SOURCES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame,
  input  logic [NUM_SOURCES-1:0]            src_req,
  input  logic [NUM_SOURCES-1:0]            src_done,
  input  logic [NUM_SOURCES*COLOR_DEPTH-1:0] src_color,
  input  logic [NUM_SOURCES-1:0]            src_transparent,
  input  logic [NUM_SOURCES-1:0]            src_active,
  input  logic [NUM_SOURCES*COORD_W-1:0]    src_x,
  input  logic [NUM_SOURCES*COORD_W-1:0]    src_y,
  output logic [NUM_SOURCES-1:0]            src_grant,
  output logic [NUM_SOURCES-1:0]            src_awaited,
  output logic [COLOR_DEPTH-1:0]            write_color_data,
  output logic                              write_transparent,
  output logic [COORD_W-1:0]                write_x_addr,
  output logic [COORD_W-1:0]                write_y_addr,
  output logic                              write_active,
  output logic [SEL_W-1:0]                  write_source_sel,
  input  logic                              write_awaited,
  output logic                              busy,
  output logic                              overrun,
  output logic                              timeout,
  output logic [SEL_W-1:0]                  timeout_id
);

  localparam int WD_W = wd_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_t             r_state;
  logic [NUM_SOURCES-1:0]   r_pending;
  logic [NUM_SOURCES-1:0]   r_grant;
  logic [SEL_W-1:0]         r_sel;
  logic [WD_W-1:0]          r_wd;
  logic [COLOR_DEPTH-1:0]   r_color;
  logic                     r_transp;
  logic [COORD_W-1:0]       r_x;
  logic [COORD_W-1:0]       r_y;
  logic                     r_active;
  logic                     r_overrun;
  logic                     r_timeout;
  logic [SEL_W-1:0]         r_tid;

  logic [NUM_SOURCES-1:0]   w_pick_onehot;
  logic [SEL_W-1:0]         w_pick_idx;
  logic                     w_pick_any;
  logic                     w_done;
  logic                     w_expire;
  logic [COLOR_DEPTH-1:0]   w_color;
  logic                     w_transp;
  logic [COORD_W-1:0]       w_x;
  logic [COORD_W-1:0]       w_y;
  logic                     w_active;

  lowest_set_picker #(
    .NUM_SOURCES (NUM_SOURCES),
    .SEL_W       (SEL_W)
  ) u_picker (
    .i_mask   (r_pending),
    .o_onehot (w_pick_onehot),
    .o_index  (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // r_grant is all-zero outside GRANT, so done from idle sources never matches.
  assign w_done   = |(src_done & r_grant);
  assign w_expire = (r_state == S_GRANT) && (r_wd == c_wd_last);

  always_comb begin
    w_color  = '0;
    w_transp = 1'b0;
    w_x      = '0;
    w_y      = '0;
    w_active = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (r_grant[i]) begin
        w_color  = src_color[i*COLOR_DEPTH +: COLOR_DEPTH];
        w_transp = src_transparent[i];
        w_x      = src_x[i*COORD_W +: COORD_W];
        w_y      = src_y[i*COORD_W +: COORD_W];
        w_active = src_active[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_grant   <= '0;
      r_sel     <= '0;
      r_wd      <= '0;
      r_color   <= '0;
      r_transp  <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_active  <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_tid     <= '0;
    end else begin
      r_overrun <= frame && (r_state != S_IDLE);
      r_timeout <= 1'b0;
      r_active  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame) begin
            r_pending <= src_req;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_pick_any) begin
            r_state <= S_IDLE;
          end else begin
            r_grant <= w_pick_onehot;
            r_sel   <= w_pick_idx;
            r_wd    <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_wd <= r_wd + 1'b1;
          if (w_done || w_expire) begin
            r_pending <= r_pending & ~r_grant;
            r_grant   <= '0;
            r_state   <= S_SCAN;
            // A coincident done suppresses the timeout report.
            if (!w_done) begin
              r_timeout <= 1'b1;
              r_tid     <= r_sel;
            end
          end else begin
            r_color  <= w_color;
            r_transp <= w_transp;
            r_x      <= w_x;
            r_y      <= w_y;
            r_active <= w_active;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign src_grant         = r_grant;
  assign src_awaited       = r_grant & {NUM_SOURCES{write_awaited}};
  assign write_color_data  = r_color;
  assign write_transparent = r_transp;
  assign write_x_addr      = r_x;
  assign write_y_addr      = r_y;
  assign write_active      = r_active;
  assign write_source_sel  = r_sel;
  assign busy              = (r_state != S_IDLE);
  assign overrun           = r_overrun;
  assign timeout           = r_timeout;
  assign timeout_id        = r_tid;

endmodule
`default_nettype wire
